// File: rtl/lbp_interp_scheduler.sv
// Shares one bilinear calc unit across the four diagonal LBP angles of a window.
// Define INTERP_ROUND_EN to round (+0x8000) the Q16 result instead of truncating.
module lbp_interp_scheduler #(
    parameter int CALC_LAT = 3,
    parameter int TIMEOUT  = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         win_valid,
    output logic         win_ready,
    input  logic [127:0] win_px,
    output logic         calc_issue,
    output logic [1:0]   calc_angle,
    output logic [7:0]   calc_a,
    output logic [7:0]   calc_b,
    output logic [7:0]   calc_c,
    output logic [7:0]   calc_d,
    input  logic         calc_done_i,
    input  logic [31:0]  calc_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_px,
    output logic         busy,
    output logic         err_o
);

    localparam int DL = CALC_LAT + TIMEOUT;
    localparam int DW = $clog2(DL + 1);
    localparam int QW = $clog2(CALC_LAT + 1);
    localparam logic [DW-1:0] DLAST = DW'(DL - 1);
    localparam logic [QW-1:0] QINIT = QW'(CALC_LAT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        HOLD
    } state_t;

    state_t        state;
    logic [127:0]  win_q;
    logic [1:0]    idx;
    logic [1:0]    nidx;
    logic [2:0]    ret_cnt;
    logic [31:0]   slots;
    logic [DW-1:0] dcnt;
    logic [QW-1:0] quiet;

    logic [31:0] sum;
    logic [7:0]  px_in;
    logic        done_v;
    logic        cap_ok;
    logic        last_now;
    logic        unused_lo;

`ifdef INTERP_ROUND_EN
    assign sum = calc_data + 32'h0000_8000;
`else
    assign sum = calc_data;
`endif

    assign px_in     = (sum[31:24] != 8'd0) ? 8'hFF : sum[23:16];
    assign unused_lo = ^sum[15:0];
    assign nidx      = idx + 2'd1;

    // Returns still in flight from before a reset land inside the quiet window.
    assign done_v   = calc_done_i && (quiet == '0);
    assign cap_ok   = ((state == ISSUE) || (state == DRAIN)) && (ret_cnt != 3'd4);
    assign last_now = done_v && cap_ok && (ret_cnt == 3'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            win_ready  <= 1'b1;
            calc_issue <= 1'b0;
            calc_angle <= 2'd0;
            calc_a     <= 8'd0;
            calc_b     <= 8'd0;
            calc_c     <= 8'd0;
            calc_d     <= 8'd0;
            out_valid  <= 1'b0;
            out_px     <= 32'd0;
            busy       <= 1'b0;
            err_o      <= 1'b0;
            win_q      <= 128'd0;
            idx        <= 2'd0;
            ret_cnt    <= 3'd0;
            slots      <= 32'd0;
            dcnt       <= '0;
            quiet      <= QINIT;
        end else begin
            if (quiet != '0)
                quiet <= quiet - 1'b1;

            if (done_v) begin
                if (cap_ok) begin
                    slots[{ret_cnt[1:0], 3'b000} +: 8] <= px_in;
                    ret_cnt <= ret_cnt + 3'd1;
                end else begin
                    err_o <= 1'b1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (win_valid) begin
                        win_q      <= win_px;
                        idx        <= 2'd0;
                        state      <= ISSUE;
                        win_ready  <= 1'b0;
                        busy       <= 1'b1;
                        calc_issue <= 1'b1;
                        calc_angle <= 2'd0;
                        {calc_d, calc_c, calc_b, calc_a} <= win_px[31:0];
                    end
                end
                ISSUE: begin
                    if (idx == 2'd3) begin
                        calc_issue <= 1'b0;
                        state      <= DRAIN;
                        dcnt       <= '0;
                    end else begin
                        idx        <= nidx;
                        calc_angle <= nidx;
                        {calc_d, calc_c, calc_b, calc_a} <= win_q[{nidx, 5'd0} +: 32];
                    end
                end
                DRAIN: begin
                    if (ret_cnt == 3'd4) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_px    <= slots;
                    end else if (dcnt == DLAST && !last_now) begin
                        err_o     <= 1'b1;
                        state     <= IDLE;
                        win_ready <= 1'b1;
                        busy      <= 1'b0;
                        ret_cnt   <= 3'd0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                        win_ready <= 1'b1;
                        busy      <= 1'b0;
                        ret_cnt   <= 3'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
